// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with frame-synchronous
// double buffering, per-slot dead time and optional leading-zero blanking.
module hex_display_scanner #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned BLANK  = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame
);

    localparam int unsigned VW = 4 * DIGITS;
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = $clog2(DIGITS);

    // Active-low segment pattern, bit 0 = a ... bit 6 = g
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h18;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [PW-1:0]     pre;
    logic [IW-1:0]     idx;
    logic [VW-1:0]     pend_val;
    logic [DIGITS-1:0] pend_dp;
    logic              pend_lz;
    logic [VW-1:0]     act_val;
    logic [DIGITS-1:0] act_dp;
    logic              act_lz;

    logic              pre_last;
    logic              idx_last;
    logic              frame_c;
    logic              drive_c;
    logic [PW-1:0]     pre_nxt;
    logic [IW-1:0]     idx_nxt;

    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic              zero_above;
    logic [6:0]        seg_nxt;
    logic              dp_n_nxt;
    logic [DIGITS-1:0] an_n_nxt;

    // Prescaler / digit index sequencing
    always_comb begin
        pre_last = (pre == PW'(DIV - 1));
        idx_last = (idx == IW'(DIGITS - 1));
        frame_c  = pre_last && idx_last;
        drive_c  = (pre >= PW'(BLANK));
        pre_nxt  = pre_last ? '0 : pre + PW'(1);
        idx_nxt  = idx;
        if (pre_last) begin
            idx_nxt = idx_last ? '0 : idx + IW'(1);
        end
    end

    // Select the current digit; zero_above tracks "this and all higher nibbles are 0"
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (act_val[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                cur_nib   = act_val[4*i +: 4];
                cur_dp    = act_dp[i];
                cur_blank = act_lz && (i != 0) && zero_above;
            end
        end
    end

    // Next output values: dead time at the start of each slot, then drive
    always_comb begin
        seg_nxt  = 7'h7F;
        dp_n_nxt = 1'b1;
        an_n_nxt = '1;
        if (drive_c) begin
            seg_nxt  = cur_blank ? 7'h7F : hex_to_seg(cur_nib);
            dp_n_nxt = ~cur_dp;
            for (int i = 0; i < DIGITS; i++) begin
                an_n_nxt[i] = (idx != IW'(i));
            end
        end
    end

    // The registered frame pulse marks the swap point, so a load seen together
    // with it lands in the very next slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre      <= '0;
            idx      <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend_lz  <= 1'b0;
            act_val  <= '0;
            act_dp   <= '0;
            act_lz   <= 1'b0;
            seg_n    <= 7'h7F;
            dp_n     <= 1'b1;
            an_n     <= '1;
            frame    <= 1'b0;
        end else begin
            pre <= pre_nxt;
            idx <= idx_nxt;
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp;
                pend_lz  <= blank_lz;
            end
            if (frame) begin
                act_val <= load ? value    : pend_val;
                act_dp  <= load ? dp       : pend_dp;
                act_lz  <= load ? blank_lz : pend_lz;
            end
            seg_n <= seg_nxt;
            dp_n  <= dp_n_nxt;
            an_n  <= an_n_nxt;
            frame <= frame_c;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: frame-level display model compared every cycle,
// plus directed literal checks of scan timing, decode, blanking and buffering.
module tb_hex_display_scanner;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int P      = DIGITS * DIV;
    localparam logic [12:0] RST_VEC = {1'b0, 4'hF, 1'b1, 7'h7F};
    localparam logic [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                           7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h18, 7'h08, 7'h03,
                                           7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame;

    int total = 0;
    int bad   = 0;

    hex_display_scanner #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .value    (value),
        .dp       (dp),
        .load     (load),
        .blank_lz (blank_lz),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .an_n     (an_n),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    // Expected outputs after the n-th rising edge since reset release
    function automatic logic [12:0] model_out(input int n_i, input logic [15:0] v,
                                              input logic [3:0] d, input logic lz);
        int          pos;
        int          slot;
        int          off;
        logic [3:0]  an;
        logic [3:0]  one;
        logic [6:0]  seg;
        logic        dpn;
        logic        frm;
        logic [15:0] upper;
        pos  = n_i % P;
        slot = pos / DIV;
        off  = pos % DIV;
        frm  = (pos == P - 1);
        an   = 4'hF;
        seg  = 7'h7F;
        dpn  = 1'b1;
        if (off >= BLANK) begin
            one   = 4'b0001;
            an    = ~(one << slot);
            dpn   = ~d[slot];
            upper = v >> (4 * slot);
            if (!(lz && slot > 0 && upper == 16'h0)) seg = SEGTAB[upper[3:0]];
        end
        return {frm, an, dpn, seg};
    endfunction

    int          n = 0;
    logic [15:0] m_pend_val = '0;
    logic [3:0]  m_pend_dp  = '0;
    logic        m_pend_lz  = 1'b0;
    logic [15:0] m_act_val  = '0;
    logic [3:0]  m_act_dp   = '0;
    logic        m_act_lz   = 1'b0;
    logic [12:0] exp_vec    = RST_VEC;

    // Double-buffer model: active data swaps on the edge following a frame pulse
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            n          <= 0;
            m_pend_val <= '0;
            m_pend_dp  <= '0;
            m_pend_lz  <= 1'b0;
            m_act_val  <= '0;
            m_act_dp   <= '0;
            m_act_lz   <= 1'b0;
            exp_vec    <= RST_VEC;
        end else begin
            exp_vec <= model_out(n, m_act_val, m_act_dp, m_act_lz);
            n       <= n + 1;
            if (load) begin
                m_pend_val <= value;
                m_pend_dp  <= dp;
                m_pend_lz  <= blank_lz;
            end
            if (n > 0 && n % P == 0) begin
                m_act_val <= load ? value    : m_pend_val;
                m_act_dp  <= load ? dp       : m_pend_dp;
                m_act_lz  <= load ? blank_lz : m_pend_lz;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic compare_loop();
        logic [12:0] e;
        forever begin
            @(negedge clk);
            e = resetn ? exp_vec : RST_VEC;
            chk("scan", 16'({frame, an_n, dp_n, seg_n}), 16'(e));
        end
    endtask

    task automatic wait_an(input logic [3:0] pat);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (an_n !== pat && k < 100);
        if (an_n !== pat) chk("wait_an", 16'(an_n), 16'(pat));
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame !== 1'b1 && k < 100);
        if (frame !== 1'b1) chk("wait_frame", 16'(frame), 16'h1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
        @(negedge clk);
        value    = v;
        dp       = d;
        blank_lz = lz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    initial begin
        int cnt;
        resetn   = 1'b0;
        value    = '0;
        dp       = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        fork
            compare_loop();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_an", 16'(an_n), 16'hF);
        chk("rst_seg", 16'(seg_n), 16'h7F);
        chk("rst_dp", 16'(dp_n), 16'h1);
        chk("rst_frame", 16'(frame), 16'h0);

        // Dead time after release, then digit 0 shows the cleared value
        resetn = 1'b1;
        @(negedge clk); chk("start_an0", 16'(an_n), 16'hF);
        @(negedge clk); chk("start_an1", 16'(an_n), 16'hF);
        @(negedge clk); chk("start_an2", 16'(an_n), 16'hE);
        chk("start_seg", 16'(seg_n), 16'h40);

        wait_frame();
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (frame !== 1'b1 && cnt < 100);
        chk("frame_period", 16'(cnt), 16'd32);

        // Basic scan with decimal points on digits 0 and 2
        do_load(16'h1234, 4'b0101, 1'b0);
        wait_frame();
        wait_an(4'hE); chk("d0_seg", 16'(seg_n), 16'h19); chk("d0_dp", 16'(dp_n), 16'h0);
        wait_an(4'hD); chk("d1_seg", 16'(seg_n), 16'h30); chk("d1_dp", 16'(dp_n), 16'h1);
        wait_an(4'hB); chk("d2_seg", 16'(seg_n), 16'h24); chk("d2_dp", 16'(dp_n), 16'h0);
        wait_an(4'h7); chk("d3_seg", 16'(seg_n), 16'h79);

        for (int k = 0; k < 16; k++) begin
            do_load(16'(k), 4'b0000, 1'b0);
            wait_frame();
            wait_an(4'hE);
            chk("sweep", 16'(seg_n), 16'(SEGTAB[k]));
            if (k == 7)  chk("dec7", 16'(seg_n), 16'h78);
            if (k == 9)  chk("dec9", 16'(seg_n), 16'h18);
            if (k == 11) chk("decb", 16'(seg_n), 16'h03);
        end

        do_load(16'h0050, 4'b0000, 1'b1);
        wait_frame();
        wait_an(4'hE); chk("lz_d0", 16'(seg_n), 16'h40);
        wait_an(4'hD); chk("lz_d1", 16'(seg_n), 16'h12);
        wait_an(4'hB); chk("lz_d2", 16'(seg_n), 16'h7F);
        wait_an(4'h7); chk("lz_d3", 16'(seg_n), 16'h7F);
        do_load(16'h0000, 4'b0000, 1'b1);
        wait_frame();
        wait_an(4'hE); chk("lz0_d0", 16'(seg_n), 16'h40);
        wait_an(4'hD); chk("lz0_d1", 16'(seg_n), 16'h7F);
        do_load(16'h0000, 4'b0000, 1'b0);
        wait_frame();
        wait_an(4'hE); chk("nolz_d0", 16'(seg_n), 16'h40);
        wait_an(4'h7); chk("nolz_d3", 16'(seg_n), 16'h40);

        // Mid-frame load must not tear the frame in progress
        do_load(16'hAAAA, 4'b0000, 1'b0);
        wait_frame();
        wait_an(4'hD); chk("tear_d1", 16'(seg_n), 16'h08);
        do_load(16'h5555, 4'b0000, 1'b0);
        wait_an(4'hB); chk("tear_d2", 16'(seg_n), 16'h08);
        wait_an(4'h7); chk("tear_d3", 16'(seg_n), 16'h08);
        wait_frame();
        wait_an(4'hE); chk("tear_next", 16'(seg_n), 16'h12);

        // Load coincident with the frame pulse bypasses into the next slot
        wait_frame();
        value = 16'hFFFF;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_an(4'hE); chk("bypass", 16'(seg_n), 16'h0E);

        wait_an(4'hB);
        #1 resetn = 1'b0;
        #1;
        chk("arst_an", 16'(an_n), 16'hF);
        chk("arst_seg", 16'(seg_n), 16'h7F);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk); chk("rel_an0", 16'(an_n), 16'hF);
        @(negedge clk); chk("rel_an1", 16'(an_n), 16'hF);
        @(negedge clk); chk("rel_an2", 16'(an_n), 16'hE);
        chk("rel_seg", 16'(seg_n), 16'h40);

        repeat (40) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
